// File: rtl/exception_ctrl_pkg.sv
// Shared encodings for the exception controller: cause codes, FSM states, default vector.
package exception_ctrl_pkg;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_UNDEF = 2'd1;
    localparam logic [1:0] CAUSE_ARITH = 2'd2;
    localparam logic [1:0] CAUSE_IRQ   = 2'd3;

    localparam logic [31:0] VECTOR_ADDR_DEFAULT = 32'h0000_FFFC;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHandler = 2'd1,
        StHalt    = 2'd2
    } state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: overflow > undefined > lowest-index pending IRQ.
module exc_prio_enc
    import exception_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic               ovf_ev,
    input  logic               undef_ev,
    input  logic [NUM_IRQ-1:0] irq_ev,
    input  logic [31:0]        ovf_pc,
    input  logic [31:0]        undef_pc,
    input  logic [31:0]        irq_pc,
    output logic               win_valid,
    output logic [1:0]         win_cause,
    output logic [1:0]         win_irq_id,
    output logic [31:0]        win_pc
);

    logic [1:0] low_id;

    // Lowest set IRQ index; scanning downward leaves the smallest index last.
    always_comb begin
        low_id = 2'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_ev[i]) begin
                low_id = 2'(i);
            end
        end
    end

    // Pick the single winning event and its restart PC.
    always_comb begin
        win_valid  = 1'b0;
        win_cause  = CAUSE_NONE;
        win_irq_id = 2'd0;
        win_pc     = 32'd0;
        if (ovf_ev) begin
            win_valid = 1'b1;
            win_cause = CAUSE_ARITH;
            win_pc    = ovf_pc;
        end else if (undef_ev) begin
            win_valid = 1'b1;
            win_cause = CAUSE_UNDEF;
            win_pc    = undef_pc;
        end else if (|irq_ev) begin
            win_valid  = 1'b1;
            win_cause  = CAUSE_IRQ;
            win_irq_id = low_id;
            win_pc     = irq_pc;
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// Exception source controller: prioritises ID/EX/IRQ events, owns EPC/Cause,
// tracks handler mode and drives the registered PC redirect / pipeline flush.
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 4,
    parameter logic [31:0] VECTOR_ADDR = VECTOR_ADDR_DEFAULT,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               undef_i,
    input  logic [31:0]        undef_pc,
    input  logic               ovf_i,
    input  logic [31:0]        ovf_pc,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [31:0]        irq_pc,
    input  logic               irq_pc_valid,
    input  logic               stall_i,
    input  logic               eret_i,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic               flush,
    output logic [31:0]        epc,
    output logic [1:0]         cause,
    output logic [1:0]         irq_id,
    output logic               in_handler,
    output logic               halted,
    output logic [CNT_W-1:0]   exc_count
);

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q, irq_q, irq_gated;
    logic               redirect_q, flush_q;
    logic [31:0]        redirect_pc_q, epc_q;
    logic [1:0]         cause_q, irq_id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               win_valid;
    logic [1:0]         win_cause, win_irq_id;
    logic [31:0]        win_pc;
    logic               take_entry, take_eret, take_halt;

    // IRQs only eligible when ID holds a real, non-stalled instruction to restart at.
    assign irq_gated = irq_q & {NUM_IRQ{irq_pc_valid & ~stall_i}};

    // ERET outside a handler is treated exactly like an undefined opcode.
    exc_prio_enc #(
        .NUM_IRQ(NUM_IRQ)
    ) u_prio (
        .ovf_ev    (ovf_i),
        .undef_ev  (undef_i | eret_i),
        .irq_ev    (irq_gated),
        .ovf_pc    (ovf_pc),
        .undef_pc  (undef_pc),
        .irq_pc    (irq_pc),
        .win_valid (win_valid),
        .win_cause (win_cause),
        .win_irq_id(win_irq_id),
        .win_pc    (win_pc)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and transition strobes. Events seen while a redirect is on the
    // wire are ignored: they belong to instructions being discarded, and this
    // keeps redirect/flush from ever firing on consecutive cycles.
    always_comb begin
        state_d    = state_q;
        take_entry = 1'b0;
        take_eret  = 1'b0;
        take_halt  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!redirect_q && win_valid) begin
                    take_entry = 1'b1;
                    state_d    = StHandler;
                end
            end
            StHandler: begin
                if (!redirect_q) begin
                    if (ovf_i || undef_i) begin
                        take_halt = 1'b1;
                        state_d   = StHalt;
                    end else if (eret_i) begin
                        take_eret = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // IRQ mask and one-cycle masked IRQ sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            irq_q  <= '0;
        end else begin
            irq_q <= irq & mask_q;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    // EPC/Cause capture on entry plus saturating entry counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc_q    <= 32'd0;
            cause_q  <= CAUSE_NONE;
            irq_id_q <= 2'd0;
            cnt_q    <= '0;
        end else if (take_entry) begin
            epc_q    <= win_pc;
            cause_q  <= win_cause;
            irq_id_q <= win_irq_id;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
            end
        end
    end

    // Registered redirect pulse; flush only accompanies handler entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            redirect_q <= take_entry | take_eret | take_halt;
            flush_q    <= take_entry;
            if (take_eret) begin
                redirect_pc_q <= epc_q;
            end else if (take_entry || take_halt) begin
                redirect_pc_q <= VECTOR_ADDR;
            end
        end
    end

    assign redirect    = redirect_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_pc_q;
    assign epc         = epc_q;
    assign cause       = cause_q;
    assign irq_id      = irq_id_q;
    assign exc_count   = cnt_q;
    assign in_handler  = (state_q == StHandler);
    assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed scenarios plus random traffic, checked by a
// behavioural model feeding a redirect scoreboard and per-cycle state checks.
module tb_exception_ctrl;

    localparam int unsigned NIRQ = 4;
    localparam logic [31:0] VEC  = 32'h0000_FFFC;
    localparam int          MIDLE = 0;
    localparam int          MHAND = 1;
    localparam int          MHALT = 2;

    logic        clk, reset;
    logic        undef_i, ovf_i, irq_pc_valid, stall_i, eret_i, mask_we;
    logic [31:0] undef_pc, ovf_pc, irq_pc;
    logic [3:0]  irq, mask_wdata;
    logic        redirect, flush, in_handler, halted;
    logic [31:0] redirect_pc, epc;
    logic [1:0]  cause, irq_id;
    logic [7:0]  exc_count;

    exception_ctrl #(
        .NUM_IRQ    (NIRQ),
        .VECTOR_ADDR(VEC),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .undef_i     (undef_i),
        .undef_pc    (undef_pc),
        .ovf_i       (ovf_i),
        .ovf_pc      (ovf_pc),
        .irq         (irq),
        .irq_pc      (irq_pc),
        .irq_pc_valid(irq_pc_valid),
        .stall_i     (stall_i),
        .eret_i      (eret_i),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .epc         (epc),
        .cause       (cause),
        .irq_id      (irq_id),
        .in_handler  (in_handler),
        .halted      (halted),
        .exc_count   (exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        flush;
    } exp_t;

    exp_t        sb[$];
    int          m_mode;
    bit          m_redir, m_took;
    logic [3:0]  m_mask, m_irqs;
    logic [31:0] m_epc;
    logic [1:0]  m_cause, m_irq_id;
    logic [7:0]  m_count;

    task automatic model_reset();
        m_mode = MIDLE; m_redir = 0; m_mask = 4'd0; m_irqs = 4'd0;
        m_epc = 32'd0; m_cause = 2'd0; m_irq_id = 2'd0; m_count = 8'd0;
    endtask

    task automatic model_enter(input logic [1:0] c, input logic [31:0] pc, input logic [1:0] id);
        exp_t e;
        e.pc = VEC; e.flush = 1'b1;
        sb.push_back(e);
        m_epc = pc; m_cause = c; m_irq_id = id;
        if (m_count != 8'hFF) m_count = m_count + 8'd1;
        m_mode = MHAND; m_took = 1;
    endtask

    task automatic model_step();
        exp_t e;
        logic [1:0] id;
        m_took = 0;
        if (!m_redir) begin
            if (m_mode == MIDLE) begin
                if (ovf_i) model_enter(2'd2, ovf_pc, 2'd0);
                else if (undef_i || eret_i) model_enter(2'd1, undef_pc, 2'd0);
                else if (irq_pc_valid && !stall_i && m_irqs != 4'd0) begin
                    id = 2'd0;
                    for (int i = 3; i >= 0; i--) if (m_irqs[i]) id = 2'(i);
                    model_enter(2'd3, irq_pc, id);
                end
            end else if (m_mode == MHAND) begin
                if (ovf_i || undef_i) begin
                    e.pc = VEC; e.flush = 1'b0; sb.push_back(e);
                    m_mode = MHALT; m_took = 1;
                end else if (eret_i) begin
                    e.pc = m_epc; e.flush = 1'b0; sb.push_back(e);
                    m_mode = MIDLE; m_took = 1;
                end
            end
        end
        m_redir = m_took;
        m_irqs = irq & m_mask;
        if (mask_we) m_mask = mask_wdata;
    endtask

    always @(posedge clk) begin
        if (reset) model_reset();
        else model_step();
    end

    // ---------------- monitor / scoreboard ----------------
    bit prev_redir = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_redir = 0;
        end else begin
            check("redirect_gap", {31'd0, prev_redir & redirect}, 32'd0);
            check("flush_without_redirect", {31'd0, flush & ~redirect}, 32'd0);
            if (redirect) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL spurious_redirect: got redirect=1 pc=%h, required no redirect", redirect_pc);
                end else begin
                    e = sb.pop_front();
                    check("redirect_pc", redirect_pc, e.pc);
                    check("redirect_flush", {31'd0, flush}, {31'd0, e.flush});
                end
            end else if (sb.size() != 0) begin
                n_checks++; n_fail++;
                $display("FAIL missing_redirect: got redirect=0, required redirect to %h", sb[0].pc);
                sb.delete();
            end
            check("in_handler", {31'd0, in_handler}, {31'd0, m_mode == MHAND});
            check("halted", {31'd0, halted}, {31'd0, m_mode == MHALT});
            check("epc", epc, m_epc);
            check("cause", {30'd0, cause}, {30'd0, m_cause});
            check("irq_id", {30'd0, irq_id}, {30'd0, m_irq_id});
            check("exc_count", {24'd0, exc_count}, {24'd0, m_count});
            prev_redir = redirect;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        undef_i = 0; ovf_i = 0; eret_i = 0; mask_we = 0; stall_i = 0; irq_pc_valid = 0;
        irq = 4'd0; mask_wdata = 4'd0; undef_pc = 32'd0; ovf_pc = 32'd0; irq_pc = 32'd0;
    endtask

    // Asynchronous reset: outputs must drop before any further clock edge.
    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        #1;
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_epc", epc, 32'd0);
        check("rst_cause", {30'd0, cause}, 32'd0);
        check("rst_irq_id", {30'd0, irq_id}, 32'd0);
        check("rst_in_handler", {31'd0, in_handler}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_exc_count", {24'd0, exc_count}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic random_inputs();
        ovf_i        = ($urandom % 10) == 0;
        undef_i      = ($urandom % 10) == 0;
        eret_i       = ($urandom % 6) == 0;
        mask_we      = ($urandom % 16) == 0;
        mask_wdata   = 4'($urandom);
        irq          = 4'($urandom);
        stall_i      = ($urandom % 3) == 0;
        irq_pc_valid = ($urandom % 4) != 0;
        undef_pc     = $urandom & 32'hFFFF_FFFC;
        ovf_pc       = $urandom & 32'hFFFF_FFFC;
        irq_pc       = $urandom & 32'hFFFF_FFFC;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        do_reset();

        // Overflow entry, then ERET back to it.
        ovf_i = 1; ovf_pc = 32'h40; tick(); clear_inputs();
        tick();
        eret_i = 1; tick(); clear_inputs();
        tick();

        // Simultaneous overflow and undefined: overflow wins, one entry counted.
        ovf_i = 1; ovf_pc = 32'h40; undef_i = 1; undef_pc = 32'h44; tick(); clear_inputs();
        check("ovf_beats_undef_cause", {30'd0, cause}, 32'd2);
        check("ovf_beats_undef_epc", epc, 32'h40);
        check("ovf_beats_undef_count", {24'd0, exc_count}, 32'd2);
        tick();
        eret_i = 1; tick(); clear_inputs();
        tick();

        // Masked IRQ: held off by stall, taken once stall drops; ERET returns to 0x80.
        mask_we = 1; mask_wdata = 4'b0100; tick(); clear_inputs();
        irq = 4'b0110; irq_pc = 32'h80; irq_pc_valid = 1; stall_i = 1;
        repeat (6) tick();
        check("irq_stalled", {31'd0, in_handler}, 32'd0);
        stall_i = 0; tick();
        check("irq_taken", {31'd0, in_handler}, 32'd1);
        check("irq_id_taken", {30'd0, irq_id}, 32'd2);
        irq = 4'd0; irq_pc_valid = 0; tick();
        eret_i = 1; tick(); clear_inputs();
        check("eret_pc", redirect_pc, 32'h80);
        tick();

        // ERET while idle behaves as undefined instruction.
        eret_i = 1; undef_pc = 32'h100; tick(); clear_inputs();
        check("idle_eret_cause", {30'd0, cause}, 32'd1);
        tick();

        // Undefined + ERET inside handler: double fault, sticky until reset.
        undef_i = 1; eret_i = 1; tick(); clear_inputs();
        for (int i = 0; i < 10; i++) begin random_inputs(); tick(); end
        clear_inputs();
        check("halt_sticky", {31'd0, halted}, 32'd1);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            tick();
            if ((m_mode == MHALT && ($urandom % 20) == 0) || ($urandom % 400) == 0) begin
                clear_inputs();
                do_reset();
            end
        end
        clear_inputs();
        do_reset();

        // Counter saturation over 300 entry/ERET pairs.
        for (int i = 0; i < 300; i++) begin
            undef_i = 1; undef_pc = 32'(i * 4); tick(); undef_i = 0;
            tick();
            eret_i = 1; tick(); eret_i = 0;
            tick();
        end
        check("count_saturated", {24'd0, exc_count}, 32'h0000_00FF);

        // Reset asserted while redirect is high.
        ovf_i = 1; ovf_pc = 32'h200; tick(); clear_inputs();
        check("redirect_before_reset", {31'd0, redirect}, 32'd1);
        do_reset();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
